// File: rtl/id_stage_pipe.sv
// id_stage_pipe: ARM instruction-decode stage with register file, condition
// check, hazard detection and the ID/EX pipeline register.
// Optional build macro FORWARD_EN: when defined, EX/MEM forwarding exists
// downstream and only load-use hazards stall; otherwise any pending write by
// the instructions in EX or MEM to a used source register stalls.
module id_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_in,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [31:0]           instruction,
    input  logic [3:0]            status,
    input  logic                  wb_en_in,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  ex_wb_en,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    output logic                  hazard,
    output logic                  valid,
    output logic [DATA_W-1:0]     pc,
    output logic [DATA_W-1:0]     reg1,
    output logic [DATA_W-1:0]     reg2,
    output logic [3:0]            alu_cmd,
    output logic [REG_ADDR_W-1:0] dest,
    output logic [REG_ADDR_W-1:0] src1,
    output logic [REG_ADDR_W-1:0] src2,
    output logic                  status_en,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_en,
    output logic                  branch,
    output logic                  imm,
    output logic [11:0]           shifter_operand,
    output logic [23:0]           b_signed_imm
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;

    logic [DATA_W-1:0]     regs [NUM_REGS];

    logic [3:0]            cond;
    logic [1:0]            mode;
    logic                  i_bit;
    logic [3:0]            opcode;
    logic                  s_bit;
    logic [REG_ADDR_W-1:0] rn;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rm;
    logic [REG_ADDR_W-1:0] src2_addr;
    logic                  is_null;

    logic                  dec_defined;
    logic [3:0]            dec_alu;
    logic                  dec_status_en;
    logic                  dec_wb;
    logic                  dec_mem_read;
    logic                  dec_mem_write;
    logic                  dec_branch;
    logic                  uses_rn;
    logic                  uses_src2;
    logic                  is_str;

    logic                  cond_pass;
    logic                  hazard_c;
    logic                  issue;
    logic [DATA_W-1:0]     reg1_val;
    logic [DATA_W-1:0]     reg2_val;

    assign cond      = instruction[31:28];
    assign mode      = instruction[27:26];
    assign i_bit     = instruction[25];
    assign opcode    = instruction[24:21];
    assign s_bit     = instruction[20];
    assign rn        = REG_ADDR_W'(instruction[19:16]);
    assign rd        = REG_ADDR_W'(instruction[15:12]);
    assign rm        = REG_ADDR_W'(instruction[3:0]);
    assign is_null   = (instruction == 32'h0);
    assign src2_addr = is_str ? rd : rm;

    // Translate mode/opcode into EX control bits and note which sources are read
    always_comb begin
        dec_defined   = 1'b0;
        dec_alu       = 4'b0000;
        dec_status_en = 1'b0;
        dec_wb        = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        uses_rn       = 1'b0;
        uses_src2     = 1'b0;
        is_str        = 1'b0;
        case (mode)
            2'b00: begin
                dec_defined   = 1'b1;
                uses_rn       = 1'b1;
                uses_src2     = ~i_bit;
                dec_wb        = 1'b1;
                dec_status_en = s_bit;
                case (opcode)
                    4'b1101: begin dec_alu = 4'b0001; uses_rn = 1'b0; end
                    4'b1111: begin dec_alu = 4'b1001; uses_rn = 1'b0; end
                    4'b0100: dec_alu = 4'b0010;
                    4'b0101: dec_alu = 4'b0011;
                    4'b0010: dec_alu = 4'b0100;
                    4'b0110: dec_alu = 4'b0101;
                    4'b0000: dec_alu = 4'b0110;
                    4'b1100: dec_alu = 4'b0111;
                    4'b0001: dec_alu = 4'b1000;
                    4'b1010: begin
                        dec_alu       = 4'b0100;
                        dec_wb        = 1'b0;
                        dec_status_en = 1'b1;
                    end
                    4'b1000: begin
                        dec_alu       = 4'b0110;
                        dec_wb        = 1'b0;
                        dec_status_en = 1'b1;
                    end
                    default: begin
                        dec_defined   = 1'b0;
                        dec_wb        = 1'b0;
                        dec_status_en = 1'b0;
                        uses_rn       = 1'b0;
                        uses_src2     = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                dec_defined = 1'b1;
                dec_alu     = 4'b0010;
                uses_rn     = 1'b1;
                if (s_bit) begin
                    dec_mem_read = 1'b1;
                    dec_wb       = 1'b1;
                end else begin
                    dec_mem_write = 1'b1;
                    is_str        = 1'b1;
                    uses_src2     = 1'b1;
                end
            end
            2'b10: begin
                dec_defined = 1'b1;
                dec_branch  = 1'b1;
            end
            default: dec_defined = 1'b0;
        endcase
    end

    // Evaluate the ARM condition field against the NZCV flags
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = status[2];
            4'b0001: cond_pass = ~status[2];
            4'b0010: cond_pass = status[1];
            4'b0011: cond_pass = ~status[1];
            4'b0100: cond_pass = status[3];
            4'b0101: cond_pass = ~status[3];
            4'b0110: cond_pass = status[0];
            4'b0111: cond_pass = ~status[0];
            4'b1000: cond_pass = status[1] & ~status[2];
            4'b1001: cond_pass = ~status[1] | status[2];
            4'b1010: cond_pass = (status[3] == status[0]);
            4'b1011: cond_pass = (status[3] != status[0]);
            4'b1100: cond_pass = ~status[2] & (status[3] == status[0]);
            4'b1101: cond_pass = status[2] | (status[3] != status[0]);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

`ifdef FORWARD_EN
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{ex_wb_en, mem_wb_en, mem_dest};

    // Only a load in EX cannot be forwarded in time, so stall on load-use alone
    always_comb begin
        hazard_c = 1'b0;
        if (!is_null && ex_mem_read) begin
            hazard_c = (uses_rn && (rn == ex_dest)) ||
                       (uses_src2 && (src2_addr == ex_dest));
        end
    end
`else
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ex_mem_read;

    // Without forwarding, any pending write in EX or MEM to a used source stalls
    always_comb begin
        hazard_c = 1'b0;
        if (!is_null) begin
            hazard_c = (uses_rn && ex_wb_en && (rn == ex_dest)) ||
                       (uses_rn && mem_wb_en && (rn == mem_dest)) ||
                       (uses_src2 && ex_wb_en && (src2_addr == ex_dest)) ||
                       (uses_src2 && mem_wb_en && (src2_addr == mem_dest));
        end
    end
`endif

    assign hazard = hazard_c;

    assign reg1_val = (wb_en_in && (wb_dest == rn))        ? wb_data : regs[rn];
    assign reg2_val = (wb_en_in && (wb_dest == src2_addr)) ? wb_data : regs[src2_addr];

    assign issue = !flush && !hazard_c && cond_pass && !is_null && dec_defined;

    // Register file: cleared on reset, written from the write-back port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en_in) begin
            regs[wb_dest] <= wb_data;
        end
    end

    // ID/EX register: flush beats stall; bubbles keep data but clear controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid           <= 1'b0;
            pc              <= '0;
            reg1            <= '0;
            reg2            <= '0;
            alu_cmd         <= 4'b0000;
            dest            <= '0;
            src1            <= '0;
            src2            <= '0;
            status_en       <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            wb_en           <= 1'b0;
            branch          <= 1'b0;
            imm             <= 1'b0;
            shifter_operand <= '0;
            b_signed_imm    <= '0;
        end else if (flush || !stall_in) begin
            pc              <= pc_in;
            reg1            <= reg1_val;
            reg2            <= reg2_val;
            dest            <= rd;
            src1            <= rn;
            src2            <= src2_addr;
            imm             <= i_bit;
            shifter_operand <= instruction[11:0];
            b_signed_imm    <= instruction[23:0];
            valid           <= issue;
            alu_cmd         <= issue ? dec_alu : 4'b0000;
            status_en       <= issue & dec_status_en;
            mem_read        <= issue & dec_mem_read;
            mem_write       <= issue & dec_mem_write;
            wb_en           <= issue & dec_wb;
            branch          <= issue & dec_branch;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed and randomized checks of id_stage_pipe against a
// mnemonic-level reference model. Honours FORWARD_EN the same way the design does.
module tb_id_stage_pipe;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [3:0]  alu_cmd;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        status_en;
        logic        mem_read;
        logic        mem_write;
        logic        wb_en;
        logic        branch;
        logic        imm;
        logic [11:0] shifter_operand;
        logic [23:0] b_signed_imm;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] instruction = '0;
    logic [3:0]  status = '0;
    logic        wb_en_in = 1'b0;
    logic [3:0]  wb_dest = '0;
    logic [31:0] wb_data = '0;
    logic        ex_wb_en = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [3:0]  ex_dest = '0;
    logic        mem_wb_en = 1'b0;
    logic [3:0]  mem_dest = '0;

    logic        hazard, valid, status_en, mem_read, mem_write, wb_en, branch, imm;
    logic [31:0] pc, reg1, reg2;
    logic [3:0]  alu_cmd, dest, src1, src2;
    logic [11:0] shifter_operand;
    logic [23:0] b_signed_imm;

    out_t        obs;
    out_t        expected;
    logic [31:0] model_regs [16];
    logic [3:0]  alu_map [string];
    int          tests = 0;
    int          failed = 0;

    id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
        .pc_in(pc_in), .instruction(instruction), .status(status),
        .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_data(wb_data),
        .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .hazard(hazard), .valid(valid), .pc(pc), .reg1(reg1), .reg2(reg2),
        .alu_cmd(alu_cmd), .dest(dest), .src1(src1), .src2(src2),
        .status_en(status_en), .mem_read(mem_read), .mem_write(mem_write),
        .wb_en(wb_en), .branch(branch), .imm(imm),
        .shifter_operand(shifter_operand), .b_signed_imm(b_signed_imm)
    );

    always #5 clk = ~clk;

    assign obs = {valid, pc, reg1, reg2, alu_cmd, dest, src1, src2, status_en,
                  mem_read, mem_write, wb_en, branch, imm, shifter_operand, b_signed_imm};

    function automatic string mnemonic(input logic [31:0] ins);
        if (ins[27:26] == 2'b01) return ins[20] ? "LDR" : "STR";
        if (ins[27:26] == 2'b10) return "B";
        if (ins[27:26] == 2'b11) return "UND";
        case (ins[24:21])
            4'b1101: return "MOV";
            4'b1111: return "MVN";
            4'b0100: return "ADD";
            4'b0101: return "ADC";
            4'b0010: return "SUB";
            4'b0110: return "SBC";
            4'b0000: return "AND";
            4'b1100: return "ORR";
            4'b0001: return "EOR";
            4'b1010: return "CMP";
            4'b1000: return "TST";
            default: return "UND";
        endcase
    endfunction

    function automatic logic arm_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] second_src(input logic [31:0] ins);
        return (mnemonic(ins) == "STR") ? ins[15:12] : ins[3:0];
    endfunction

    function automatic logic pending_write(input logic [3:0] a);
`ifdef FORWARD_EN
        return ex_mem_read && (a == ex_dest);
`else
        return (ex_wb_en && a == ex_dest) || (mem_wb_en && a == mem_dest);
`endif
    endfunction

    function automatic logic ref_hazard(input logic [31:0] ins);
        string m;
        logic  rn_used, s2_used;
        m = mnemonic(ins);
        if (ins == 32'h0 || m == "UND") return 1'b0;
        rn_used = !(m == "MOV" || m == "MVN" || m == "B");
        s2_used = (ins[27:26] == 2'b00 && !ins[25]) || m == "STR";
        return (rn_used && pending_write(ins[19:16])) ||
               (s2_used && pending_write(second_src(ins)));
    endfunction

    function automatic logic [31:0] read_bypass(input logic [3:0] a);
        return (wb_en_in && wb_dest == a) ? wb_data : model_regs[a];
    endfunction

    // What the stage should register this cycle given the present inputs
    function automatic out_t ref_next(input logic hz);
        out_t  r;
        string m;
        logic  go, dp;
        r = '0;
        m = mnemonic(instruction);
        r.pc              = pc_in;
        r.src1            = instruction[19:16];
        r.src2            = second_src(instruction);
        r.reg1            = read_bypass(r.src1);
        r.reg2            = read_bypass(r.src2);
        r.dest            = instruction[15:12];
        r.imm             = instruction[25];
        r.shifter_operand = instruction[11:0];
        r.b_signed_imm    = instruction[23:0];
        go = !flush && !hz && arm_cond(instruction[31:28], status) &&
             instruction != 32'h0 && m != "UND";
        if (!flush && stall_in) return expected;
        if (go) begin
            dp          = (instruction[27:26] == 2'b00);
            r.valid     = 1'b1;
            r.alu_cmd   = alu_map[m];
            r.status_en = (m == "CMP" || m == "TST") ? 1'b1 : (dp && instruction[20]);
            r.wb_en     = (m == "LDR") || (dp && m != "CMP" && m != "TST");
            r.mem_read  = (m == "LDR");
            r.mem_write = (m == "STR");
            r.branch    = (m == "B");
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [3:0]  c;
        logic [3:0]  op;
        logic [1:0]  md;
        logic        s;
        int          kind;
        logic [31:0] r;
        c    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE;
        kind = $urandom_range(0, 15);
        s    = 1'($urandom);
        md   = 2'b00;
        case (kind)
            0: op = 4'b1101;  1: op = 4'b1111;  2: op = 4'b0100;
            3: op = 4'b0101;  4: op = 4'b0010;  5: op = 4'b0110;
            6: op = 4'b0000;  7: op = 4'b1100;  8: op = 4'b0001;
            9: op = 4'b1010; 10: op = 4'b1000;
            11: begin md = 2'b01; op = 4'($urandom); s = 1'b1; end
            12: begin md = 2'b01; op = 4'($urandom); s = 1'b0; end
            13: begin md = 2'b10; op = 4'($urandom); end
            14: begin md = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b00; op = 4'b0011; end
            default: op = 4'b0000;
        endcase
        r = {c, md, 1'($urandom), op, s, 20'($urandom)};
        if (kind == 15) r = 32'h0;
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] exp_v);
        tests++;
        assert (observed === exp_v) else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, exp_v);
        end
    endtask

    // One clock cycle: check hazard, clock, then check the registered outputs
    task automatic apply_stimulus();
        logic hz;
        out_t nxt;
        #1;
        hz = ref_hazard(instruction);
        if (mnemonic(instruction) != "UND") check_output("hazard", 32'(hazard), 32'(hz));
        nxt = ref_next(hz);
        @(posedge clk);
        if (wb_en_in) model_regs[wb_dest] = wb_data;
        expected = nxt;
        #1;
        tests++;
        assert (obs === expected) else begin
            failed++;
            $error("[TB] FAIL outputs observed=%h expected=%h", obs, expected);
        end
        @(negedge clk);
    endtask

    task automatic clear_side_inputs();
        wb_en_in = 0; ex_wb_en = 0; ex_mem_read = 0; mem_wb_en = 0;
        stall_in = 0; flush = 0;
    endtask

    initial begin
        logic hz_const;
        alu_map["MOV"] = 4'b0001; alu_map["MVN"] = 4'b1001; alu_map["ADD"] = 4'b0010;
        alu_map["ADC"] = 4'b0011; alu_map["SUB"] = 4'b0100; alu_map["SBC"] = 4'b0101;
        alu_map["AND"] = 4'b0110; alu_map["ORR"] = 4'b0111; alu_map["EOR"] = 4'b1000;
        alu_map["CMP"] = 4'b0100; alu_map["TST"] = 4'b0110; alu_map["LDR"] = 4'b0010;
        alu_map["STR"] = 4'b0010; alu_map["B"]   = 4'b0000; alu_map["UND"] = 4'b0000;
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        expected = '0;

        #1 rst = 1'b1;
        #2;
        check_output("reset_valid", 32'(valid), 32'h0);
        check_output("reset_all", 32'(obs != '0), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Preload R2=5 and R3=7 through the write-back port
        wb_en_in = 1; wb_dest = 4'd2; wb_data = 32'd5; apply_stimulus();
        wb_dest = 4'd3; wb_data = 32'd7; apply_stimulus();
        wb_en_in = 0;

        pc_in = 32'h100; instruction = 32'hE082_1003; apply_stimulus();
        check_output("add_valid", 32'(valid), 32'h1);
        check_output("add_alu", 32'(alu_cmd), 32'h2);
        check_output("add_reg1", reg1, 32'd5);
        check_output("add_reg2", reg2, 32'd7);
        check_output("add_dest", 32'(dest), 32'h1);
        check_output("add_wb", 32'(wb_en), 32'h1);

        instruction = 32'h0052_1003; status = 4'b0000; apply_stimulus();
        check_output("subs_eq_fail_valid", 32'(valid), 32'h0);
        check_output("subs_eq_fail_sen", 32'(status_en), 32'h0);
        status = 4'b0100; apply_stimulus();
        check_output("subs_eq_pass_valid", 32'(valid), 32'h1);
        check_output("subs_eq_pass_sen", 32'(status_en), 32'h1);
        status = 4'b0000;

`ifdef FORWARD_EN
        hz_const = 1'b0;
`else
        hz_const = 1'b1;
`endif
        instruction = 32'hE082_1003; ex_dest = 4'd2; ex_wb_en = 1;
        #1 check_output("ex_hazard", 32'(hazard), 32'(hz_const));
        apply_stimulus();
        check_output("ex_hazard_valid", 32'(valid), 32'(!hz_const));
        ex_mem_read = 1;
        #1 check_output("load_use_hazard", 32'(hazard), 32'h1);
        apply_stimulus();
        check_output("load_use_valid", 32'(valid), 32'h0);
        clear_side_inputs();

        wb_en_in = 1; wb_dest = 4'd4; wb_data = 32'hDEAD; instruction = 32'hE1A0_0004;
        apply_stimulus();
        check_output("bypass_reg2", reg2, 32'hDEAD);
        check_output("mov_alu", 32'(alu_cmd), 32'h1);
        wb_en_in = 0;

        pc_in = 32'h200; instruction = 32'hE406_5000; apply_stimulus();
        check_output("str_src2", 32'(src2), 32'h5);
        check_output("str_mem_write", 32'(mem_write), 32'h1);
        stall_in = 1; instruction = 32'hE082_1003; pc_in = 32'h204;
        for (int k = 0; k < 2; k++) begin
            apply_stimulus();
            check_output("stall_hold_pc", pc, 32'h200);
            check_output("stall_hold_mw", 32'(mem_write), 32'h1);
        end
        flush = 1; apply_stimulus();
        check_output("flush_valid", 32'(valid), 32'h0);
        check_output("flush_mw", 32'(mem_write), 32'h0);
        clear_side_inputs();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            instruction = rand_instr();
            pc_in       = $urandom;
            status      = 4'($urandom);
            wb_en_in    = ($urandom_range(0, 1) == 1);
            wb_dest     = 4'($urandom);
            wb_data     = $urandom;
            ex_wb_en    = ($urandom_range(0, 9) < 3);
            ex_mem_read = ($urandom_range(0, 9) < 2);
            ex_dest     = 4'($urandom);
            mem_wb_en   = ($urandom_range(0, 9) < 3);
            mem_dest    = 4'($urandom);
            stall_in    = ($urandom_range(0, 9) == 0);
            flush       = ($urandom_range(0, 11) == 0);
            apply_stimulus();
        end
        clear_side_inputs();

        // Make sure something is registered, then reset asynchronously
        instruction = 32'hE082_1003; apply_stimulus();
        #2 rst = 1'b1;
        #1;
        check_output("midreset_valid", 32'(valid), 32'h0);
        check_output("midreset_all", 32'(obs != '0), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        expected = '0;
        for (int i = 0; i < 16; i++) model_regs[i] = '0;

        for (int k = 0; k < 8; k++) begin
            instruction = {4'hE, 8'h08, 4'(2 * k), 4'(k), 8'h00, 4'(2 * k + 1)};
            apply_stimulus();
            check_output("regfile_cleared_a", reg1, 32'h0);
            check_output("regfile_cleared_b", reg2, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
